// File: rtl/bsg_manycore_block_mem_responder.sv
// Word-addressed backing memory for a block-mem column: services load, masked store and AMO
// requests against a local array and returns one in-order response per request via a 2-entry FIFO.
module bsg_manycore_block_mem_responder #(
    parameter int unsigned data_width_p        = 32,
    parameter int unsigned addr_width_p        = 28,
    parameter int unsigned mem_size_in_words_p = 1024,
    parameter int unsigned tag_width_p         = 16,
    localparam int unsigned mask_width_lp      = data_width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [2:0]               op_i,
    input  logic [addr_width_p-1:0]  addr_i,
    input  logic [data_width_p-1:0]  data_i,
    input  logic [mask_width_lp-1:0] mask_i,
    input  logic [tag_width_p-1:0]   tag_i,

    output logic                     v_o,
    input  logic                     ready_i,
    output logic [data_width_p-1:0]  data_o,
    output logic [tag_width_p-1:0]   tag_o,
    output logic                     store_o,
    output logic                     err_o
);

    localparam int unsigned IdxWidthLp =
        (mem_size_in_words_p > 1) ? $clog2(mem_size_in_words_p) : 1;
    // One extra bit so a memory that fills the whole address space still compares correctly.
    localparam logic [addr_width_p:0] MemSizeLp = (addr_width_p + 1)'(mem_size_in_words_p);

    localparam logic [2:0] OpLoad = 3'd0;
    localparam logic [2:0] OpStore = 3'd1;
    localparam logic [2:0] OpSwap = 3'd2;
    localparam logic [2:0] OpAdd = 3'd3;
    localparam logic [2:0] OpOr = 3'd4;

    logic [data_width_p-1:0] mem_q [mem_size_in_words_p];

    logic [1:0] count_q, count_d;
    logic       head_q, tail_q;

    logic [data_width_p-1:0] rsp_data_q  [2];
    logic [tag_width_p-1:0]  rsp_tag_q   [2];
    logic                    rsp_store_q [2];
    logic                    rsp_err_q   [2];

    logic                    accept, deq;
    logic                    req_err, do_write, is_store;
    logic [IdxWidthLp-1:0]   idx;
    logic [data_width_p-1:0] old_data, new_data, rsp_data;

    assign ready_o = reset_n_i & (count_q < 2'd2);
    assign accept  = v_i & ready_o;
    assign v_o     = (count_q != 2'd0);
    assign deq     = v_o & ready_i;
    assign idx     = addr_i[IdxWidthLp-1:0];

    always_comb begin
        req_err  = ({1'b0, addr_i} >= MemSizeLp) | (op_i > OpOr);
        is_store = (op_i == OpStore);
        old_data = mem_q[idx];
        new_data = old_data;
        rsp_data = old_data;
        do_write = 1'b0;
        case (op_i)
            OpLoad: ;
            OpStore: begin
                rsp_data = '0;
                do_write = 1'b1;
                for (int b = 0; b < int'(mask_width_lp); b++) begin
                    if (mask_i[b]) begin
                        new_data[8*b +: 8] = data_i[8*b +: 8];
                    end
                end
            end
            OpSwap: begin
                new_data = data_i;
                do_write = 1'b1;
            end
            OpAdd: begin
                new_data = old_data + data_i;
                do_write = 1'b1;
            end
            OpOr: begin
                new_data = old_data | data_i;
                do_write = 1'b1;
            end
            default: ;
        endcase
        if (req_err) begin
            do_write = 1'b0;
            rsp_data = '0;
        end
    end

    // Memory is deliberately left out of reset so contents survive a mid-run reset.
    always_ff @(posedge clk_i) begin
        if (accept && do_write) begin
            mem_q[idx] <= new_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            rsp_data_q[tail_q]  <= rsp_data;
            rsp_tag_q[tail_q]   <= tag_i;
            rsp_store_q[tail_q] <= is_store;
            rsp_err_q[tail_q]   <= req_err;
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, accept} - {1'b0, deq};
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (accept) tail_q <= ~tail_q;
            if (deq)    head_q <= ~head_q;
        end
    end

    // Gate the head entry so an empty FIFO presents all-zero outputs.
    assign data_o  = v_o ? rsp_data_q[head_q]  : '0;
    assign tag_o   = v_o ? rsp_tag_q[head_q]   : '0;
    assign store_o = v_o ? rsp_store_q[head_q] : 1'b0;
    assign err_o   = v_o ? rsp_err_q[head_q]   : 1'b0;

endmodule
